// File: rtl/btn_pkg.sv
// Shared constants for the front-panel button sequencer: FSM state
// encoding, default timing parameters and a small sizing helper.
package btn_pkg;

  // Default number of debounced buttons on the front panel
  localparam int N_BTN_DEF     = 4;
  // Default press-to-long-press delay, in 1 kHz clock cycles
  localparam int LONG_MS_DEF   = 1000;
  // Default auto-repeat period, in 1 kHz clock cycles
  localparam int REPEAT_MS_DEF = 200;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PRESS        = 2'd1;
  localparam logic [1:0] ST_REPEAT       = 2'd2;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

  // Larger of two integers, used to size the shared hold timer
  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_hold_timer.sv
// Hold timer for the button sequencer. Counts enabled cycles and raises
// o_done in the cycle where the count is one short of i_limit, so the
// caller's registered strobe lands exactly i_limit cycles after the
// last clear. The counter restarts from zero on done, so it never wraps.
module btn_hold_timer #(
  parameter int TW = 4
) (
  input  logic          clk_1khz,
  input  logic          rst_n,
  input  logic          i_clear,
  input  logic          i_enable,
  input  logic [TW-1:0] i_limit,
  output logic          o_done
);

  logic [TW-1:0] r_count;
  logic [TW-1:0] w_last;

  assign w_last = i_limit - TW'(1);
  // Done is gated by enable so a released owner can never fire a strobe
  assign o_done = i_enable & (r_count == w_last);

  // Cycle counter: clear wins, otherwise count while enabled and restart on done
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= {TW{1'b0}};
    end else if (i_clear) begin
      r_count <= {TW{1'b0}};
    end else if (i_enable) begin
      if (o_done) begin
        r_count <= {TW{1'b0}};
      end else begin
        r_count <= r_count + TW'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/btn_sequencer.sv
// Front-panel button sequencer. One button at a time owns the block; an
// owned press yields a press command, then a long-press command, then
// periodic auto-repeat commands until the owner is released. All outputs
// come straight from registers.
module btn_sequencer
  import btn_pkg::*;
#(
  parameter int N_BTN     = N_BTN_DEF,
  parameter int LONG_MS   = LONG_MS_DEF,
  parameter int REPEAT_MS = REPEAT_MS_DEF
) (
  input  logic                     clk_1khz,
  input  logic                     rst_n,
  input  logic [N_BTN-1:0]         btn_db,
  output logic                     cmd_valid,
  output logic [$clog2(N_BTN)-1:0] cmd_id,
  output logic                     cmd_long,
  output logic                     cmd_repeat,
  output logic                     busy
);

  localparam int IW = $clog2(N_BTN);
  localparam int TW = $clog2(max_int(LONG_MS, REPEAT_MS) + 1);
  localparam logic [TW-1:0] LONG_LIM   = TW'(LONG_MS);
  localparam logic [TW-1:0] REPEAT_LIM = TW'(REPEAT_MS);

  logic [N_BTN-1:0] r_btn_q;
  logic [1:0]       r_state;

  logic [N_BTN-1:0] w_rise;
  logic             w_any_rise;
  logic [IW-1:0]    w_first_idx;
  logic             w_owner_hi;
  logic             w_all_low;
  logic             w_timer_clr;
  logic             w_timer_en;
  logic [TW-1:0]    w_limit;
  logic             w_done;

  logic [1:0]       w_state_nx;
  logic             w_valid_nx;
  logic             w_long_nx;
  logic             w_repeat_nx;
  logic [IW-1:0]    w_id_nx;

  // A button held through reset has r_btn_q=1 and so produces no rise
  assign w_rise      = btn_db & ~r_btn_q;
  assign w_any_rise  = |w_rise;
  assign w_owner_hi  = btn_db[cmd_id];
  assign w_all_low   = ~(|btn_db);

  // Timer runs only while an owner is held in PRESS or REPEAT
  assign w_timer_clr = (r_state == ST_IDLE) | (r_state == ST_WAIT_RELEASE);
  assign w_timer_en  = ((r_state == ST_PRESS) | (r_state == ST_REPEAT)) & w_owner_hi;
  assign w_limit     = (r_state == ST_PRESS) ? LONG_LIM : REPEAT_LIM;

  btn_hold_timer #(
    .TW (TW)
  ) u_hold_timer (
    .clk_1khz (clk_1khz),
    .rst_n    (rst_n),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .i_limit  (w_limit),
    .o_done   (w_done)
  );

  // Priority encoder: lowest set index of the rise vector wins
  always_comb begin
    w_first_idx = {IW{1'b0}};
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_first_idx = IW'(i);
      end else begin
        w_first_idx = w_first_idx;
      end
    end
  end

  // Next-state and command decode; owner release always beats a timer event
  always_comb begin
    w_state_nx  = r_state;
    w_valid_nx  = 1'b0;
    w_long_nx   = 1'b0;
    w_repeat_nx = 1'b0;
    w_id_nx     = cmd_id;
    case (r_state)
      ST_IDLE: begin
        if (w_any_rise) begin
          w_id_nx    = w_first_idx;
          w_valid_nx = 1'b1;
          w_state_nx = ST_PRESS;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_PRESS: begin
        if (!w_owner_hi) begin
          w_state_nx = ST_WAIT_RELEASE;
        end else if (w_done) begin
          w_valid_nx = 1'b1;
          w_long_nx  = 1'b1;
          w_state_nx = ST_REPEAT;
        end else begin
          w_state_nx = ST_PRESS;
        end
      end
      ST_REPEAT: begin
        if (!w_owner_hi) begin
          w_state_nx = ST_WAIT_RELEASE;
        end else if (w_done) begin
          w_valid_nx  = 1'b1;
          w_repeat_nx = 1'b1;
        end else begin
          w_state_nx = ST_REPEAT;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_all_low) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_WAIT_RELEASE;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Edge register, FSM state and registered command outputs
  always_ff @(posedge clk_1khz or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_q    <= {N_BTN{1'b1}};
      r_state    <= ST_IDLE;
      cmd_valid  <= 1'b0;
      cmd_id     <= {IW{1'b0}};
      cmd_long   <= 1'b0;
      cmd_repeat <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_btn_q    <= btn_db;
      r_state    <= w_state_nx;
      cmd_valid  <= w_valid_nx;
      cmd_id     <= w_id_nx;
      cmd_long   <= w_long_nx;
      cmd_repeat <= w_repeat_nx;
      busy       <= (w_state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_btn_sequencer.sv
// Directed bench for btn_sequencer with N_BTN=4, LONG_MS=10, REPEAT_MS=4.
// Each vector drives btn_db for one cycle and checks the registered
// outputs just after the clock edge that consumed it.
module tb_btn_sequencer;

  logic       clk_1khz;
  logic       rst_n;
  logic [3:0] btn_db;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_long;
  logic       cmd_repeat;
  logic       busy;

  int n_vec;
  int n_err;

  typedef struct {
    logic [3:0] btn;
    logic [5:0] exp;   // {valid, id[1:0], long, repeat, busy}
    int         tag;
  } vec_t;

  vec_t tbl[$];

  btn_sequencer #(
    .N_BTN     (4),
    .LONG_MS   (10),
    .REPEAT_MS (4)
  ) dut (
    .clk_1khz   (clk_1khz),
    .rst_n      (rst_n),
    .btn_db     (btn_db),
    .cmd_valid  (cmd_valid),
    .cmd_id     (cmd_id),
    .cmd_long   (cmd_long),
    .cmd_repeat (cmd_repeat),
    .busy       (busy)
  );

  initial clk_1khz = 1'b0;
  always #5 clk_1khz = ~clk_1khz;

  function automatic logic [5:0] pk(input logic v, input logic [1:0] id,
                                    input logic l, input logic r, input logic b);
    pk = {v, id, l, r, b};
  endfunction

  task automatic add(input logic [3:0] b, input logic v, input logic [1:0] id,
                     input logic l, input logic r, input logic bz, input int tag);
    vec_t e;
    e.btn = b;
    e.exp = pk(v, id, l, r, bz);
    e.tag = tag;
    tbl.push_back(e);
  endtask

  // Compare outputs now, without a clock edge
  task automatic chk_now(input logic [5:0] exp, input int tag);
    logic [5:0] got;
    got = {cmd_valid, cmd_id, cmd_long, cmd_repeat, busy};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL vec%0d {valid,id,long,rep,busy} got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one input cycle, then compare just after the consuming edge
  task automatic chk(input logic [3:0] b, input logic [5:0] exp, input int tag);
    btn_db = b;
    @(posedge clk_1khz);
    #1;
    chk_now(exp, tag);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    btn_db = 4'b0010;

    // Reset held with button 1 pressed
    #1;
    chk_now(6'b000000, 1);
    chk(4'b0010, 6'b000000, 2);
    chk(4'b0010, 6'b000000, 3);
    rst_n = 1'b1;

    // Test 1: button held through reset must not fire; re-press does
    for (int i = 0; i < 30; i++) add(4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 100 + i);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 130);
    add(4'b0010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 131);
    add(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 132);
    add(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 133);

    // Test 2: short press of button 2
    add(4'b0100, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 200);
    for (int i = 1; i < 5; i++) add(4'b0100, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 200 + i);
    add(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 205);
    add(4'b0000, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 206);

    // Test 3: button 0 held 25 cycles: press, long at +10, repeats at +14/+18/+22
    for (int j = 0; j < 25; j++) begin
      if (j == 0)
        add(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 300 + j);
      else if (j == 10)
        add(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 300 + j);
      else if (j == 14 || j == 18 || j == 22)
        add(4'b0001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 300 + j);
      else
        add(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 300 + j);
    end
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 325);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 326);

    // Test 4: simultaneous rise of bits 1 and 3; drop owner while bit 3 held
    add(4'b1010, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 400);
    for (int i = 1; i < 4; i++) add(4'b1010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 400 + i);
    for (int i = 4; i < 8; i++) add(4'b1000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 400 + i);
    add(4'b0000, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 408);

    // Test 5: release on the exact cycle the long-press would fire
    add(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 500);
    for (int j = 1; j < 10; j++) add(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 500 + j);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 510);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 511);

    // Test 6: pulse of button 2 during REPEAT is ignored, cadence unchanged
    for (int j = 0; j < 24; j++) begin
      if (j == 0)
        add(4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 600 + j);
      else if (j == 10)
        add(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 600 + j);
      else if (j == 14 || j == 18 || j == 22)
        add(4'b0001, 1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 600 + j);
      else if (j == 15)
        add(4'b0101, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 600 + j);
      else
        add(4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 600 + j);
    end
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 624);
    add(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 625);

    foreach (tbl[k]) chk(tbl[k].btn, tbl[k].exp, tbl[k].tag);

    // Async reset mid-hold: outputs drop at once, no strobe until a fresh rise
    chk(4'b0011, pk(1'b1, 2'd0, 1'b0, 1'b0, 1'b1), 700);
    for (int j = 1; j < 10; j++) chk(4'b0011, pk(1'b0, 2'd0, 1'b0, 1'b0, 1'b1), 700 + j);
    chk(4'b0011, pk(1'b1, 2'd0, 1'b1, 1'b0, 1'b1), 710);
    #2;
    rst_n = 1'b0;
    #1;
    chk_now(6'b000000, 711);
    chk(4'b0011, 6'b000000, 712);
    rst_n = 1'b1;
    for (int j = 0; j < 6; j++) chk(4'b0011, 6'b000000, 713 + j);
    chk(4'b0000, 6'b000000, 720);
    chk(4'b0010, pk(1'b1, 2'd1, 1'b0, 1'b0, 1'b1), 721);
    chk(4'b0000, pk(1'b0, 2'd1, 1'b0, 1'b0, 1'b1), 722);
    chk(4'b0000, pk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0), 723);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
